// File: rtl/reg_file.sv
// reg_file: integer register file for the single-cycle datapath.
// Two combinational read ports (ALU A/B operands), one clocked write port
// (writeback), and a three-bit condition-code register latched from the ALU.
// Register 0 has no storage and always reads as zero.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write-port value
// onto a read port addressing the same register in the same cycle.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  rd_we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flag_we,
  input  logic                  alu_cout,
  input  logic                  alu_over,
  input  logic                  alu_zero,
  output logic                  flag_cout,
  output logic                  flag_over,
  output logic                  flag_zero
);

  localparam int NREG = 1 << ADDR_WIDTH;

  // Storage exists only for indices 1 .. NREG-1; index 0 is synthesised as a constant.
  logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
  logic [2:0]            flags_q;
  logic [2:0]            flags_d;
  logic                  wr_en;

  // A write to index 0 is dropped here so the array never sees it.
  always_comb begin
    wr_en = rd_we && (rd_addr != '0);
  end

  // Register array: reset clears every entry, and takes priority over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  // Flag next state: capture the live ALU flags on request, otherwise hold.
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {alu_cout, alu_over, alu_zero};
    end
  end

  // Flag register with reset overriding flag_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign {flag_cout, flag_over, flag_zero} = flags_q;

  // Read port 1: zero for index 0, optional same-cycle forwarding, else stored value.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && !rst && (rs1_addr == rd_addr)) begin
        rs1_data = rd_data;
      end
`endif
    end
  end

  // Read port 2: identical to port 1, fully independent.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      rs2_data = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && !rst && (rs2_addr == rd_addr)) begin
        rs2_data = rd_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic checked against an array-based model.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam bit BYP = `ifdef REGFILE_BYPASS_EN 1'b1 `else 1'b0 `endif ;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [DW-1:0] rs1_data, rs2_data, rd_data;
  logic          rd_we, flag_we;
  logic          alu_cout, alu_over, alu_zero;
  logic          flag_cout, flag_over, flag_zero;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .flag_we  (flag_we),
    .alu_cout (alu_cout),
    .alu_over (alu_over),
    .alu_zero (alu_zero),
    .flag_cout(flag_cout),
    .flag_over(flag_over),
    .flag_zero(flag_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain array of register contents plus a flag triple.
  logic [DW-1:0] mdl [2**AW];
  logic [2:0]    mflg;

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    rst = r; rd_we = we; rd_addr = wa; rd_data = wd;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic set_alu(input bit fwe, input bit c, input bit o, input bit z);
    flag_we = fwe; alu_cout = c; alu_over = o; alu_zero = z;
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && rd_we && !rst && rd_addr != 0 && rd_addr == a) return rd_data;
    return mdl[a];
  endfunction

  task automatic model_check(input string tag);
    #1;
    chk({tag, "_rs1"}, rs1_data, mread(rs1_addr));
    chk({tag, "_rs2"}, rs2_data, mread(rs2_addr));
    chk({tag, "_flags"}, {flag_cout, flag_over, flag_zero}, mflg);
  endtask

  // Advance one clock edge, applying the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
      mflg = 3'b000;
    end else begin
      if (rd_we && rd_addr != 0) mdl[rd_addr] = rd_data;
      if (flag_we) mflg = {alu_cout, alu_over, alu_zero};
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW:0] sum;
    logic [AW-1:0] a1, wa;

    drive(1'b1, 1'b0, '0, '0, '0, '0);
    set_alu(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset state
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd31);
    #1;
    chk("reset_rs1", rs1_data, 0);
    chk("reset_rs2", rs2_data, 0);
    chk("reset_flags", {flag_cout, flag_over, flag_zero}, 3'b000);
    tick();

    // Directed table
    tbl[0] = '{1'b1, 5'd3,  32'd100,        5'd1,  5'd2,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd4,  32'hFFFF_FFFF,  5'd3,  5'd0,  32'd100,      32'h0};
    tbl[2] = '{1'b1, 5'd0,  32'h1234_5678,  5'd3,  5'd4,  32'd100,      32'hFFFF_FFFF};
    tbl[3] = '{1'b0, 5'd0,  32'h0,          5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd7,  32'd1,          5'd3,  5'd3,  32'd100,      32'd100};
    tbl[5] = '{1'b1, 5'd31, 32'hAAAA_5555,  5'd7,  5'd4,  32'd1,        32'hFFFF_FFFF};
    tbl[6] = '{1'b1, 5'd31, 32'h13,         5'd31, 5'd31,
               BYP ? 32'h13 : 32'hAAAA_5555, BYP ? 32'h13 : 32'hAAAA_5555};
    tbl[7] = '{1'b0, 5'd0,  32'h0,          5'd31, 5'd7,  32'h13,       32'd1};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("tbl%0d_rs1", i), rs1_data, tbl[i].e1);
      chk($sformatf("tbl%0d_rs2", i), rs2_data, tbl[i].e2);
      tick();
    end

    // Operands x3 + x4 as the ALU would add them
    drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd4);
    #1;
    sum = {1'b0, rs1_data} + {1'b0, rs2_data};
    chk("alu_add_res", sum[DW-1:0], 99);
    chk("alu_add_cout", sum[DW], 1);
    tick();

    // Same-cycle read during write of x7
    drive(1'b0, 1'b1, 5'd7, 32'd2, 5'd7, 5'd0);
    #1;
    chk("raw_pre_edge", rs1_data, BYP ? 2 : 1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd7, 5'd0);
    #1;
    chk("raw_post_edge", rs1_data, 2);

    // Back-to-back writes: last edge wins
    drive(1'b0, 1'b1, 5'd10, 32'd5, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd10, 32'd6, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd10, 5'd10);
    #1;
    chk("b2b_last_wins", rs2_data, 6);

    // Flags: capture add 1 + 0x7FFFFFFF (cout=0, over=1, zero=0), then hold
    set_alu(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_alu(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("flags_capture", {flag_cout, flag_over, flag_zero}, 3'b010);
    tick();
    set_alu(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("flags_hold", {flag_cout, flag_over, flag_zero}, 3'b010);
    tick();

    // Reset clears registers and flags, overriding flag_we
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    set_alu(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd3);
    #1;
    chk("pre_rst_x5", rs1_data, 32'hDEAD_BEEF);
    chk("pre_rst_flags", {flag_cout, flag_over, flag_zero}, 3'b111);
    drive(1'b1, 1'b0, '0, '0, 5'd5, 5'd3);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd3);
    set_alu(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_rst_x5", rs1_data, 0);
    chk("post_rst_x3", rs2_data, 0);
    chk("post_rst_flags", {flag_cout, flag_over, flag_zero}, 3'b000);

    // Reset and write on the same edge: write lost, no forwarding under reset
    drive(1'b1, 1'b1, 5'd9, 32'd55, 5'd9, 5'd0);
    #1;
    chk("rst_wr_nobypass", rs1_data, 0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd9, 5'd9);
    #1;
    chk("rst_wr_lost", rs1_data, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wa = AW'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      drive(($urandom_range(0, 24) == 0), bit'($urandom_range(0, 1)), wa,
            $urandom, a1, ($urandom_range(0, 3) == 0) ? wa : AW'($urandom));
      set_alu(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      model_check("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
